uart_rx_data_frame: RTL

Serial UART receiver that sits directly downstream of the transmit data-bit stage: it samples the `tx` line produced by the transmitter (start bit, LSB-first data bits, optional parity, one stop bit) and presents each received word in parallel with a one-cycle valid pulse. It is used as the receive half of the board UART and as the loopback checker for the transmit path. It runs on the single system clock and needs no other timing reference.

---
 rtl/uart_rx_data_frame.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_data_frame.sv
// UART receiver: start, LSB-first data, optional even parity, one stop bit.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_data_frame #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [NrOfDataBits-1:0] dataBits,
    output logic                    dataValid,
    output logic                    frameError
);

    localparam int BitCycles = ClockFrequency / BaudRate;
    localparam int PhaseW    = $clog2(BitCycles);
    localparam int IdxW      = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BitCycles - 1);
    localparam logic [PhaseW-1:0] PhaseHalf = PhaseW'(BitCycles / 2 - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NrOfDataBits - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_meta_d;
    logic                    rx_sync_q, rx_sync_d;
    logic [PhaseW-1:0]       phase_q, phase_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [NrOfDataBits-1:0] shift_q, shift_d;
    logic [NrOfDataBits-1:0] data_bits_q, data_bits_d;
    logic                    data_valid_q, data_valid_d;
    logic                    frame_error_q, frame_error_d;
    logic                    parity_fault;

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_fault = ^{shift_q, parity_bit_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) parity_bit_q <= 1'b0;
        else       parity_bit_q <= parity_bit_d;
    end
`else
    assign parity_fault = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            phase_q       <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_bits_q   <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_bits_q   <= data_bits_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rx_meta_d     = rx;
        rx_sync_d     = rx_meta_q;
        phase_d       = phase_q + PhaseW'(1);
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_bits_d   = data_bits_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d  = parity_bit_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                idx_d   = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (phase_q == PhaseHalf) begin
                    phase_d = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (phase_q == PhaseLast) begin
                    phase_d                   = '0;
                    shift_d                   = shift_q >> 1;
                    shift_d[NrOfDataBits-1]   = rx_sync_q;
                    idx_d                     = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (phase_q == PhaseLast) begin
                    phase_d      = '0;
                    parity_bit_d = rx_sync_q;
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    if (rx_sync_q && !parity_fault) begin
                        data_bits_d  = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        state_d       = rx_sync_q ? S_IDLE : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dataBits   = data_bits_q;
    assign dataValid  = data_valid_q;
    assign frameError = frame_error_q;

endmodule
